seq_multiplier: RTL and testbench

Parametrised sequential shift-add multiplier producing a full 2*WIDTH-bit product over WIDTH iterations with a start/done handshake. It supports unsigned and sign-magnitude-corrected two's-complement modes, selected per operation. It is the datapath-level successor of the fixed 16-bit shift-add multiplier and sits behind the ALU as its multi-cycle multiply unit.

---
 rtl/seq_multiplier.sv | 93 +++++++++
 tb/tb_seq_multiplier.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: one add/shift step per cycle, full 2*WIDTH-bit product.
// Signed operation multiplies operand magnitudes and negates the result when the signs differ.
module seq_multiplier #(
   parameter int WIDTH     = 16,
   parameter bit SIGNED_EN = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               signed_mode,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic [WIDTH-1:0]   multiplier,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t             state;
   logic [WIDTH-1:0]   m_reg;
   logic [WIDTH-1:0]   a_reg;
   logic [WIDTH-1:0]   q_reg;
   logic               c_reg;
   logic               neg_flag;
   logic [CW-1:0]      count;

   logic               use_signed;
   logic [WIDTH-1:0]   m_mag;
   logic [WIDTH-1:0]   q_mag;
   logic [WIDTH:0]     sum;
   logic [2*WIDTH-1:0] raw;

   // The most negative operand maps onto 2^(WIDTH-1), which still fits unsigned.
   always_comb begin
      use_signed = signed_mode & SIGNED_EN;
      m_mag      = (use_signed && multiplicand[WIDTH-1]) ? -multiplicand : multiplicand;
      q_mag      = (use_signed && multiplier[WIDTH-1])   ? -multiplier   : multiplier;
      sum        = {c_reg, a_reg} + (q_reg[0] ? {1'b0, m_reg} : {(WIDTH+1){1'b0}});
      raw        = {a_reg, q_reg};
   end

   // NOTE: all state, outputs included, uses non-blocking assignments so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         product  <= '0;
         m_reg    <= '0;
         a_reg    <= '0;
         q_reg    <= '0;
         c_reg    <= 1'b0;
         neg_flag <= 1'b0;
         count    <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  m_reg    <= m_mag;
                  q_reg    <= q_mag;
                  neg_flag <= use_signed & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
                  a_reg    <= '0;
                  c_reg    <= 1'b0;
                  count    <= '0;
                  busy     <= 1'b1;
                  state    <= RUN;
               end
            end
            RUN: begin
               if (count == CW'(WIDTH)) begin
                  product <= neg_flag ? (~raw) + 1'b1 : raw;
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  state   <= IDLE;
               end else begin
                  // Conditional add into {C,A}, then shift {C,A,Q} right with 0 into C.
                  c_reg <= 1'b0;
                  a_reg <= sum[WIDTH:1];
                  q_reg <= {sum[0], q_reg[WIDTH-1:1]};
                  count <= count + CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: a driver issues operations, a reference model
// queues expected products with due cycles, and a monitor compares every cycle.
module tb_seq_multiplier;

   localparam int W = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          smode;
   logic [W-1:0]  ma;
   logic [W-1:0]  mb;
   logic          busy;
   logic          done;
   logic [2*W-1:0] product;

   logic          start8;
   logic [7:0]    m8;
   logic [7:0]    q8;
   logic          busy8;
   logic          done8;
   logic [15:0]   prod8;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [2*W-1:0] prod;
      int             due;
   } exp_t;

   exp_t           sb[$];
   int             cyc = 0;
   logic           m_busy = 1'b0;
   int             m_left = 0;
   logic [2*W-1:0] last_prod = '0;

   always #5 clk = ~clk;

   seq_multiplier #(.WIDTH(W), .SIGNED_EN(1'b1)) dut (
      .clk(clk), .rst(rst), .start(start), .signed_mode(smode),
      .multiplicand(ma), .multiplier(mb),
      .busy(busy), .done(done), .product(product)
   );

   seq_multiplier #(.WIDTH(8), .SIGNED_EN(1'b0)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .signed_mode(1'b1),
      .multiplicand(m8), .multiplier(q8),
      .busy(busy8), .done(done8), .product(prod8)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] m, input logic [W-1:0] q,
                                              input logic sm);
      int          sa, sb_;
      int unsigned ua, ub;
      if (sm) begin
         sa = int'($signed(m));
         sb_ = int'($signed(q));
         return 32'(sa * sb_);
      end
      ua = 32'(m);
      ub = 32'(q);
      return ua * ub;
   endfunction

   // Reference model: one operation in flight, accepted only while free,
   // result due WIDTH+1 edges after the accepting edge.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy <= 1'b0;
         m_left <= 0;
         sb.delete();
      end else begin
         cyc <= cyc + 1;
         if (!m_busy && start) begin
            sb.push_back('{ref_mul(ma, mb, smode), cyc + 1 + W + 1});
            m_busy <= 1'b1;
            m_left <= W + 1;
         end else if (m_busy) begin
            m_left <= m_left - 1;
            if (m_left == 1) m_busy <= 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (rst) last_prod = '0;
      check("busy", 64'(busy), 64'(m_busy));
      if (sb.size() > 0 && cyc >= sb[0].due) begin
         check("done_pulse", 64'(done), 64'd1);
         check("product", 64'(product), 64'(sb[0].prod));
         last_prod = sb[0].prod;
         void'(sb.pop_front());
      end else begin
         check("done_idle", 64'(done), 64'd0);
         check("product_hold", 64'(product), 64'(last_prod));
      end
   end

   task automatic wait_idle();
      for (int i = 0; i < 40 && m_busy; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic op(input logic [W-1:0] m, input logic [W-1:0] q, input logic sm);
      wait_idle();
      @(posedge clk); #1;
      start = 1'b1; ma = m; mb = q; smode = sm;
      @(posedge clk); #1;
      start = 1'b0; ma = W'($urandom); mb = W'($urandom); smode = 1'($urandom);
      wait_idle();
   endtask

   task automatic run8(input logic [7:0] m, input logic [7:0] q);
      int n;
      @(posedge clk); #1;
      start8 = 1'b1; m8 = m; q8 = q;
      @(posedge clk); #1;
      start8 = 1'b0; m8 = 8'($urandom); q8 = 8'($urandom);
      check("busy8_start", 64'(busy8), 64'd1);
      n = 0;
      while (n < 20) begin
         @(posedge clk); #1;
         n++;
         if (done8) break;
      end
      check("latency8", 64'(n), 64'd9);
      check("product8", 64'(prod8), 64'(16'(m) * 16'(q)));
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; smode = 1'b0; ma = '0; mb = '0;
      start8 = 1'b0; m8 = '0; q8 = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      op(16'hFFFF, 16'hFFFF, 1'b0);
      op(16'hFFFD, 16'h0005, 1'b1);
      op(16'hFFFD, 16'h0005, 1'b0);
      op(16'h8000, 16'h8000, 1'b1);
      op(16'h8000, 16'h0001, 1'b1);
      op(16'h0000, 16'h8000, 1'b1);

      // Start pulses with fresh operands while busy must be ignored.
      @(posedge clk); #1;
      start = 1'b1; ma = 16'h1234; mb = 16'hFEDC; smode = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(posedge clk); #1;
         start = 1'($urandom); ma = W'($urandom); mb = W'($urandom); smode = 1'($urandom);
      end
      start = 1'b0;
      wait_idle();

      for (int i = 0; i < 20; i++) op(W'($urandom), W'($urandom), 1'($urandom));

      // Start held high: each free cycle picks up whatever operands are present.
      for (int i = 0; i < 80; i++) begin
         @(posedge clk); #1;
         start = 1'b1; ma = W'($urandom); mb = W'($urandom); smode = 1'($urandom);
      end
      start = 1'b0;
      wait_idle();

      // Reset during iteration 8 aborts the operation without a done pulse.
      @(posedge clk); #1;
      start = 1'b1; ma = 16'h7FFF; mb = 16'h8001; smode = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (7) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      op(16'h7FFF, 16'h8001, 1'b1);

      run8(8'hFF, 8'h02);
      for (int i = 0; i < 5; i++) run8(8'($urandom), 8'($urandom));

      repeat (3) @(posedge clk);
      check("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
